// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - Decode/execute status in, pipeline hold/flush controls out
interface pipe_hazard_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  id_instr;
  logic [6:0]       ex_opcode;
  logic [4:0]       ex_rd_addr;
  logic             branch_taken;
  logic             mem_busy;
  logic             halt_req;
  logic             resume;
  logic             pc_hold;
  logic             id_hold;
  logic             id_bubble;
  logic             if_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_instr, ex_opcode, ex_rd_addr, branch_taken, mem_busy, halt_req, resume,
    input  pc_hold, id_hold, id_bubble, if_flush, halted, stall_cnt
  );

  modport slave (
    input  id_instr, ex_opcode, ex_rd_addr, branch_taken, mem_busy, halt_req, resume,
    output pc_hold, id_hold, id_bubble, if_flush, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - Front-end sequencer: load-use stall, redirect flush, memory wait, debug halt
module pipe_hazard_ctrl #(
  parameter int XLEN      = 32,
  parameter int FETCH_LAT = 2,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int FC_W = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, HALTED} state_t;

  state_t           state, state_n;
  logic [FC_W-1:0]  flush_cnt, flush_cnt_n;
  logic [CNT_W-1:0] stall_cnt;
  logic [XLEN-1:0]  instr;
  logic [6:0]       id_op;
  logic [4:0]       id_rs1, id_rs2;
  logic             rs1_used, rs2_used, load_use;
  logic             pc_hold_c, id_hold_c, id_bubble_c, if_flush_c;
  logic             unused_instr_bits;

  assign instr             = hz.id_instr;
  assign id_op             = instr[6:0];
  assign id_rs1            = instr[19:15];
  assign id_rs2            = instr[24:20];
  assign unused_instr_bits = ^{instr[XLEN-1:25], instr[13:7]};

  // CSR immediate forms (funct3[2]=1) carry a uimm in the rs1 field, not a register
  assign rs1_used = (id_op == OP_IMM) || (id_op == OP_REG) || (id_op == OP_LOAD) ||
                    (id_op == OP_STORE) || (id_op == OP_BRANCH) || (id_op == OP_JALR) ||
                    ((id_op == OP_SYSTEM) && !instr[14]);
  assign rs2_used = (id_op == OP_REG) || (id_op == OP_STORE) || (id_op == OP_BRANCH);

  assign load_use = (hz.ex_opcode == OP_LOAD) && (hz.ex_rd_addr != 5'd0) &&
                    ((rs1_used && (id_rs1 == hz.ex_rd_addr)) ||
                     (rs2_used && (id_rs2 == hz.ex_rd_addr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    pc_hold_c   = 1'b0;
    id_hold_c   = 1'b0;
    id_bubble_c = 1'b0;
    if_flush_c  = 1'b0;
    case (state)
      RUN: begin
        if (hz.branch_taken) begin
          if_flush_c  = 1'b1;
          id_bubble_c = 1'b1;
          if (FETCH_LAT > 1) begin
            state_n     = FLUSH;
            flush_cnt_n = FC_W'(FETCH_LAT - 1);
          end
        end else if (hz.mem_busy) begin
          pc_hold_c = 1'b1;
          id_hold_c = 1'b1;
          state_n   = MEM_WAIT;
        end else if (load_use) begin
          pc_hold_c   = 1'b1;
          id_bubble_c = 1'b1;
        end else if (hz.halt_req) begin
          pc_hold_c   = 1'b1;
          id_bubble_c = 1'b1;
          state_n     = HALTED;
        end
      end
      FLUSH: begin
        // Redirect costs FETCH_LAT flush cycles in total, including the RUN cycle that saw the branch
        if_flush_c  = 1'b1;
        id_bubble_c = 1'b1;
        if (flush_cnt <= FC_W'(1)) begin
          state_n     = RUN;
          flush_cnt_n = '0;
        end else begin
          flush_cnt_n = flush_cnt - FC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.mem_busy) begin
          pc_hold_c = 1'b1;
          id_hold_c = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
      HALTED: begin
        pc_hold_c   = 1'b1;
        id_bubble_c = 1'b1;
        if (hz.resume) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  assign hz.pc_hold   = pc_hold_c & ~rst;
  assign hz.id_hold   = id_hold_c & ~rst;
  assign hz.id_bubble = id_bubble_c & ~rst;
  assign hz.if_flush  = if_flush_c & ~rst;
  assign hz.halted    = (state == HALTED) & ~rst;
  assign hz.stall_cnt = stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (pc_hold_c && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - Scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] ADD_X5   = 32'h00728333;
  localparam logic [31:0] ADDI_X0  = 32'h00100093;
  localparam logic [31:0] LUI_X5   = 32'h000282B7;
  localparam logic [31:0] JAL_X5   = 32'h000280EF;
  localparam logic [31:0] SW_X5    = 32'h00512023;
  localparam logic [31:0] CSRRW_X5 = 32'h00029073;
  localparam logic [31:0] CSRRWI_5 = 32'h0002D073;
  localparam logic [6:0]  OP_LD    = 7'b0000011;
  localparam logic [6:0]  OP_ADDI  = 7'b0010011;
  localparam logic [6:0]  OP_ST    = 7'b0100011;

  // expected control vector: {pc_hold, id_hold, id_bubble, if_flush, halted}
  localparam logic [4:0] C_IDLE = 5'b00000;
  localparam logic [4:0] C_LU   = 5'b10100;
  localparam logic [4:0] C_MW   = 5'b11000;
  localparam logic [4:0] C_FL   = 5'b00110;
  localparam logic [4:0] C_HT   = 5'b10101;

  typedef struct {
    string       tag;
    logic [4:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] exp_cnt2 = '0;
  exp_t        sb[$];

  pipe_hazard_ctrl_if #(.XLEN(32), .CNT_W(16)) hz ();
  pipe_hazard_ctrl_if #(.XLEN(32), .CNT_W(2))  hz2 ();

  pipe_hazard_ctrl #(.XLEN(32), .FETCH_LAT(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  pipe_hazard_ctrl #(.XLEN(32), .FETCH_LAT(1), .CNT_W(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .hz  (hz2)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic sb_compare(input logic [4:0] act_ctl, input logic [15:0] act_cnt, input logic both);
    exp_t e;
    e = sb.pop_front();
    check_val({e.tag, "_ctl"}, 32'(act_ctl), 32'(e.ctl));
    check_val({e.tag, "_cnt"}, 32'(act_cnt), 32'(e.cnt));
    check_val({e.tag, "_hold_and_bubble"}, 32'(both), 32'd0);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [6:0] op, input logic [4:0] rd,
                       input logic br, input logic mb, input logic hr, input logic rs);
    hz.id_instr     = instr;
    hz.ex_opcode    = op;
    hz.ex_rd_addr   = rd;
    hz.branch_taken = br;
    hz.mem_busy     = mb;
    hz.halt_req     = hr;
    hz.resume       = rs;
  endtask

  task automatic observe_main();
    sb_compare({hz.pc_hold, hz.id_hold, hz.id_bubble, hz.if_flush, hz.halted},
               hz.stall_cnt, hz.id_hold & hz.id_bubble);
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic [6:0] op,
                      input logic [4:0] rd, input logic br, input logic mb, input logic hr,
                      input logic rs, input logic [4:0] exp_ctl);
    drive(instr, op, rd, br, mb, hr, rs);
    sb.push_back('{tag, exp_ctl, exp_cnt});
    if (exp_ctl[4] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    observe_main();
    @(posedge clk);
    #1;
  endtask

  task automatic step_small(input string tag, input logic br, input logic hr, input logic [4:0] exp_ctl);
    hz2.branch_taken = br;
    hz2.halt_req     = hr;
    sb.push_back('{tag, exp_ctl, exp_cnt2});
    if (exp_ctl[4] && exp_cnt2 != 16'd3) exp_cnt2 = exp_cnt2 + 16'd1;
    @(negedge clk);
    sb_compare({hz2.pc_hold, hz2.id_hold, hz2.id_bubble, hz2.if_flush, hz2.halted},
               16'(hz2.stall_cnt), hz2.id_hold & hz2.id_bubble);
    @(posedge clk);
    #1;
  endtask

  initial begin
    hz2.id_instr = NOP; hz2.ex_opcode = OP_ADDI; hz2.ex_rd_addr = 5'd0;
    hz2.branch_taken = 1'b0; hz2.mem_busy = 1'b0; hz2.halt_req = 1'b0; hz2.resume = 1'b0;
    // stimulus that would stall if reset did not gate the outputs
    drive(ADD_X5, OP_LD, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    sb.push_back('{"reset", C_IDLE, 16'd0});
    observe_main();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    step("idle",         NOP,      OP_ADDI, 5'd0, 0, 0, 0, 0, C_IDLE);
    step("lu_add",       ADD_X5,   OP_LD,   5'd5, 0, 0, 0, 0, C_LU);
    step("lu_done",      ADD_X5,   OP_ADDI, 5'd0, 0, 0, 0, 0, C_IDLE);
    step("lw_rd0",       ADDI_X0,  OP_LD,   5'd0, 0, 0, 0, 0, C_IDLE);
    step("lw_lui",       LUI_X5,   OP_LD,   5'd5, 0, 0, 0, 0, C_IDLE);
    step("lw_jal",       JAL_X5,   OP_LD,   5'd5, 0, 0, 0, 0, C_IDLE);
    step("lu_sw_rs2",    SW_X5,    OP_LD,   5'd5, 0, 0, 0, 0, C_LU);
    step("lu_csrrw",     CSRRW_X5, OP_LD,   5'd5, 0, 0, 0, 0, C_LU);
    step("lw_csrrwi",    CSRRWI_5, OP_LD,   5'd5, 0, 0, 0, 0, C_IDLE);
    step("store_in_ex",  ADD_X5,   OP_ST,   5'd5, 0, 0, 0, 0, C_IDLE);

    step("redirect_1",   NOP,      OP_ADDI, 5'd0, 1, 0, 0, 0, C_FL);
    step("redirect_2",   ADD_X5,   OP_LD,   5'd5, 0, 0, 1, 0, C_FL);
    step("redirect_end", NOP,      OP_ADDI, 5'd0, 0, 0, 0, 0, C_IDLE);

    step("mem_wait_1",   NOP,      OP_ADDI, 5'd0, 0, 1, 0, 0, C_MW);
    step("mem_wait_2",   NOP,      OP_ADDI, 5'd0, 1, 1, 0, 0, C_MW);
    step("mem_wait_3",   NOP,      OP_ADDI, 5'd0, 0, 1, 0, 0, C_MW);
    step("mem_wait_end", NOP,      OP_ADDI, 5'd0, 0, 0, 0, 0, C_IDLE);
    step("mem_run",      ADD_X5,   OP_LD,   5'd5, 0, 0, 0, 0, C_LU);

    step("prio_all",     ADD_X5,   OP_LD,   5'd5, 1, 1, 0, 0, C_FL);
    step("prio_flush",   NOP,      OP_ADDI, 5'd0, 0, 1, 0, 0, C_FL);
    step("prio_run",     NOP,      OP_ADDI, 5'd0, 0, 0, 0, 0, C_IDLE);
    step("mem_over_lu",  ADD_X5,   OP_LD,   5'd5, 0, 1, 1, 0, C_MW);
    step("mem_exit",     NOP,      OP_ADDI, 5'd0, 0, 0, 1, 0, C_IDLE);

    step("halt_enter",   NOP,      OP_ADDI, 5'd0, 0, 0, 1, 0, C_LU);
    step("halted_1",     NOP,      OP_ADDI, 5'd0, 0, 0, 0, 0, C_HT);
    step("halted_br",    NOP,      OP_ADDI, 5'd0, 1, 1, 0, 0, C_HT);
    step("resume",       NOP,      OP_ADDI, 5'd0, 0, 0, 0, 1, C_HT);
    step("resumed",      NOP,      OP_ADDI, 5'd0, 0, 0, 0, 0, C_IDLE);
    step("halt_again",   NOP,      OP_ADDI, 5'd0, 0, 0, 1, 0, C_LU);
    step("resume_hreq",  NOP,      OP_ADDI, 5'd0, 0, 0, 1, 1, C_HT);
    step("re_halt",      NOP,      OP_ADDI, 5'd0, 0, 0, 1, 0, C_LU);
    step("resume_2",     NOP,      OP_ADDI, 5'd0, 0, 0, 0, 1, C_HT);
    step("run_2",        NOP,      OP_ADDI, 5'd0, 0, 0, 0, 0, C_IDLE);

    step("flush_pre_rst", NOP,     OP_ADDI, 5'd0, 1, 0, 0, 0, C_FL);
    drive(NOP, OP_ADDI, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    sb.push_back('{"rst_in_flush", C_IDLE, 16'd0});
    observe_main();
    exp_cnt = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    step("after_rst",    NOP,      OP_ADDI, 5'd0, 0, 0, 0, 0, C_IDLE);

    step_small("lat1_redirect", 1'b1, 1'b0, C_FL);
    step_small("lat1_run",      1'b0, 1'b0, C_IDLE);
    step_small("sat_enter",     1'b0, 1'b1, C_LU);
    for (int i = 0; i < 5; i++) step_small("sat_hold", 1'b0, 1'b1, C_HT);
    check_val("sat_final", 32'(hz2.stall_cnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
